// File: rtl/urv_writeback_pkg.sv
// Shared definitions for the writeback stage: load funct3 codes and FSM states.
package urv_writeback_pkg;

   localparam logic [2:0] LP_FUN_LB  = 3'b000;
   localparam logic [2:0] LP_FUN_LH  = 3'b001;
   localparam logic [2:0] LP_FUN_LW  = 3'b010;
   localparam logic [2:0] LP_FUN_LBU = 3'b100;
   localparam logic [2:0] LP_FUN_LHU = 3'b101;

   typedef enum logic {
      ST_IDLE,
      ST_WAIT_LOAD
   } wb_state_t;

endpackage

// File: rtl/urv_load_align.sv
// Load data alignment: selects byte/halfword by address, sign- or zero-extends.
module urv_load_align
   import urv_writeback_pkg::*;
(
   input  logic [2:0]  i_fun,
   input  logic [1:0]  i_addr,
   input  logic [31:0] i_data,
   output logic [31:0] o_result
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Pick the addressed lane, then extend according to funct3.
   always_comb begin
      case (i_addr)
         2'd0:    w_byte = i_data[7:0];
         2'd1:    w_byte = i_data[15:8];
         2'd2:    w_byte = i_data[23:16];
         default: w_byte = i_data[31:24];
      endcase
      w_half = i_addr[1] ? i_data[31:16] : i_data[15:0];
      case (i_fun)
         LP_FUN_LB:  o_result = {{24{w_byte[7]}}, w_byte};
         LP_FUN_LBU: o_result = {24'd0, w_byte};
         LP_FUN_LH:  o_result = {{16{w_half[15]}}, w_half};
         LP_FUN_LHU: o_result = {16'd0, w_half};
         default:    o_result = i_data;
      endcase
   end

endmodule

// File: rtl/urv_writeback.sv
// Writeback stage: retires execute results, completes loads, drives the
// register-file write port and the X-stage bypass.
module urv_writeback
   import urv_writeback_pkg::*;
#(
   parameter int unsigned G_LOAD_TIMEOUT = 0,
   parameter int unsigned G_TIMEOUT_BITS = 8
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        x_valid_i,
   input  logic [4:0]  x_rd_i,
   input  logic        x_rd_write_i,
   input  logic [31:0] x_rd_value_i,
   input  logic        x_load_i,
   input  logic [2:0]  x_fun_i,
   input  logic [1:0]  x_dm_addr_i,
   input  logic [31:0] dm_data_l_i,
   input  logic        dm_load_done_i,
   output logic        w_stall_o,
   output logic [4:0]  w_rd_o,
   output logic [31:0] w_rd_value_o,
   output logic        w_rd_store_o,
   output logic        w_bypass_rd_write_o,
   output logic [31:0] w_bypass_rd_value_o,
   output logic        w_load_err_o
);

   // Counter value seen during the last permitted WAIT_LOAD cycle.
   localparam logic [G_TIMEOUT_BITS-1:0] LP_TO_LAST =
      G_TIMEOUT_BITS'((G_LOAD_TIMEOUT == 0) ? 0 : G_LOAD_TIMEOUT - 1);

   wb_state_t r_state;
   wb_state_t w_state_nxt;

   logic        w_stall;
   logic        w_capture_x;
   logic        w_capture_ld;
   logic        w_enter_wait;
   logic        w_timeout;
   logic [2:0]  w_al_fun;
   logic [1:0]  w_al_addr;
   logic [31:0] w_al_result;

   logic [4:0]  r_ld_rd;
   logic        r_ld_wr;
   logic [2:0]  r_ld_fun;
   logic [1:0]  r_ld_addr;
   logic [G_TIMEOUT_BITS-1:0] r_cnt;

   logic [4:0]  r_rd;
   logic [31:0] r_value;
   logic        r_store;
   logic        r_err;

   // State register.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state decode and per-cycle control strobes.
   always_comb begin
      w_state_nxt  = r_state;
      w_stall      = 1'b0;
      w_capture_x  = 1'b0;
      w_capture_ld = 1'b0;
      w_enter_wait = 1'b0;
      w_timeout    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (x_valid_i) begin
               if (x_load_i && !dm_load_done_i) begin
                  w_enter_wait = 1'b1;
                  w_state_nxt  = ST_WAIT_LOAD;
               end else begin
                  w_capture_x = 1'b1;
               end
            end
         end
         ST_WAIT_LOAD: begin
            w_stall = 1'b1;
            if (dm_load_done_i) begin
               w_capture_ld = 1'b1;
               w_state_nxt  = ST_IDLE;
            end else if ((G_LOAD_TIMEOUT != 0) && (r_cnt == LP_TO_LAST)) begin
               w_timeout   = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Aligner sees the live instruction in IDLE and the parked load while waiting.
   always_comb begin
      w_al_fun  = (r_state == ST_WAIT_LOAD) ? r_ld_fun  : x_fun_i;
      w_al_addr = (r_state == ST_WAIT_LOAD) ? r_ld_addr : x_dm_addr_i;
   end

   urv_load_align u_align (
      .i_fun    (w_al_fun),
      .i_addr   (w_al_addr),
      .i_data   (dm_data_l_i),
      .o_result (w_al_result)
   );

   // Park the pending load's attributes and run the timeout counter.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_ld_rd   <= '0;
         r_ld_wr   <= 1'b0;
         r_ld_fun  <= '0;
         r_ld_addr <= '0;
         r_cnt     <= '0;
      end else if (w_enter_wait) begin
         r_ld_rd   <= x_rd_i;
         r_ld_wr   <= x_rd_write_i && (x_rd_i != 5'd0);
         r_ld_fun  <= x_fun_i;
         r_ld_addr <= x_dm_addr_i;
         r_cnt     <= '0;
      end else if (r_state == ST_WAIT_LOAD) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // Writeback pipeline register; store and error are single-cycle pulses.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_rd    <= '0;
         r_value <= '0;
         r_store <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_store <= 1'b0;
         r_err   <= w_timeout;
         if (w_capture_x) begin
            r_rd    <= x_rd_i;
            r_value <= x_load_i ? w_al_result : x_rd_value_i;
            r_store <= x_rd_write_i && (x_rd_i != 5'd0);
         end else if (w_capture_ld) begin
            r_rd    <= r_ld_rd;
            r_value <= w_al_result;
            r_store <= r_ld_wr;
         end
      end
   end

   assign w_stall_o           = w_stall;
   assign w_rd_o              = r_rd;
   assign w_rd_value_o        = r_value;
   assign w_rd_store_o        = r_store;
   assign w_bypass_rd_write_o = r_store;
   assign w_bypass_rd_value_o = r_value;
   assign w_load_err_o        = r_err;

endmodule

// File: tb/tb_urv_writeback.sv
// Self-checking bench for urv_writeback with a 4-cycle load timeout.
module tb_urv_writeback;

   localparam int LOAD_TO = 4;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        x_valid_i;
   logic [4:0]  x_rd_i;
   logic        x_rd_write_i;
   logic [31:0] x_rd_value_i;
   logic        x_load_i;
   logic [2:0]  x_fun_i;
   logic [1:0]  x_dm_addr_i;
   logic [31:0] dm_data_l_i;
   logic        dm_load_done_i;
   logic        w_stall_o;
   logic [4:0]  w_rd_o;
   logic [31:0] w_rd_value_o;
   logic        w_rd_store_o;
   logic        w_bypass_rd_write_o;
   logic [31:0] w_bypass_rd_value_o;
   logic        w_load_err_o;

   int checks = 0;
   int errors = 0;

   always #5 clk_i = ~clk_i;

   urv_writeback #(.G_LOAD_TIMEOUT(LOAD_TO), .G_TIMEOUT_BITS(8)) dut (
      .clk_i               (clk_i),
      .rst_i               (rst_i),
      .x_valid_i           (x_valid_i),
      .x_rd_i              (x_rd_i),
      .x_rd_write_i        (x_rd_write_i),
      .x_rd_value_i        (x_rd_value_i),
      .x_load_i            (x_load_i),
      .x_fun_i             (x_fun_i),
      .x_dm_addr_i         (x_dm_addr_i),
      .dm_data_l_i         (dm_data_l_i),
      .dm_load_done_i      (dm_load_done_i),
      .w_stall_o           (w_stall_o),
      .w_rd_o              (w_rd_o),
      .w_rd_value_o        (w_rd_value_o),
      .w_rd_store_o        (w_rd_store_o),
      .w_bypass_rd_write_o (w_bypass_rd_write_o),
      .w_bypass_rd_value_o (w_bypass_rd_value_o),
      .w_load_err_o        (w_load_err_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference load result from the ISA rules, by shifting and masking.
   function automatic logic [31:0] ref_load(input logic [2:0] fun, input logic [1:0] addr,
                                            input logic [31:0] d);
      logic [31:0] v;
      int unsigned sh;
      case (fun)
         3'd0, 3'd4: begin
            sh = 8 * addr;
            v  = (d >> sh) & 32'h0000_00FF;
            if (fun == 3'd0 && v >= 32'd128) v = v + 32'hFFFF_FF00;
         end
         3'd1, 3'd5: begin
            sh = (addr >= 2'd2) ? 16 : 0;
            v  = (d >> sh) & 32'h0000_FFFF;
            if (fun == 3'd1 && v >= 32'd32768) v = v + 32'hFFFF_0000;
         end
         default: v = d;
      endcase
      return v;
   endfunction

   task automatic scramble_x();
      x_rd_i       = 5'($urandom);
      x_rd_write_i = 1'($urandom);
      x_rd_value_i = $urandom;
      x_load_i     = 1'($urandom);
      x_fun_i      = 3'($urandom);
      x_dm_addr_i  = 2'($urandom);
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_store"}, w_rd_store_o, 0);
      chk({tag, "_byp"},   w_bypass_rd_write_o, 0);
      chk({tag, "_err"},   w_load_err_o, 0);
      chk({tag, "_stall"}, w_stall_o, 0);
   endtask

   // One idle cycle, optionally with a stray done pulse that must be ignored.
   task automatic idle(input bit stray_done);
      x_valid_i      = 1'b0;
      dm_load_done_i = stray_done;
      dm_data_l_i    = $urandom;
      @(posedge clk_i); #1;
      dm_load_done_i = 1'b0;
      chk_quiet("idle");
   endtask

   // Presents one instruction in the current (non-stalled) cycle and returns
   // in the cycle its result (or timeout) is visible. delay: cycles from
   // acceptance to done; 0 = done together with acceptance.
   task automatic run_instr(input string tag, input logic [4:0] rd, input logic wr,
                            input logic [31:0] val, input logic ld, input logic [2:0] fun,
                            input logic [1:0] addr, input logic [31:0] data, input int delay);
      logic exp_wr;
      int   waits;
      chk({tag, "_pre_stall"}, w_stall_o, 0);
      x_valid_i    = 1'b1;
      x_rd_i       = rd;
      x_rd_write_i = wr;
      x_rd_value_i = val;
      x_load_i     = ld;
      x_fun_i      = fun;
      x_dm_addr_i  = addr;
      dm_load_done_i = ld && (delay == 0);
      dm_data_l_i    = (ld && delay == 0) ? data : $urandom;
      @(posedge clk_i); #1;
      x_valid_i      = 1'b0;
      dm_load_done_i = 1'b0;
      scramble_x();
      exp_wr = wr && (rd != 5'd0);
      if (ld && delay > 0) begin
         waits = (delay > LOAD_TO) ? LOAD_TO : delay;
         for (int k = 1; k <= waits; k++) begin
            chk({tag, "_wait_stall"}, w_stall_o, 1);
            chk({tag, "_wait_store"}, w_rd_store_o, 0);
            chk({tag, "_wait_byp"},   w_bypass_rd_write_o, 0);
            chk({tag, "_wait_err"},   w_load_err_o, 0);
            x_valid_i = 1'($urandom);
            scramble_x();
            dm_load_done_i = (k == delay);
            dm_data_l_i    = (k == delay) ? data : $urandom;
            @(posedge clk_i); #1;
            x_valid_i      = 1'b0;
            dm_load_done_i = 1'b0;
         end
         if (delay > LOAD_TO) begin
            chk({tag, "_to_err"},   w_load_err_o, 1);
            chk({tag, "_to_store"}, w_rd_store_o, 0);
            chk({tag, "_to_byp"},   w_bypass_rd_write_o, 0);
            chk({tag, "_to_stall"}, w_stall_o, 0);
            return;
         end
      end
      chk({tag, "_store"},   w_rd_store_o, exp_wr);
      chk({tag, "_byp_wr"},  w_bypass_rd_write_o, exp_wr);
      chk({tag, "_rd"},      w_rd_o, rd);
      chk({tag, "_value"},   w_rd_value_o, ld ? ref_load(fun, addr, data) : val);
      chk({tag, "_byp_val"}, w_bypass_rd_value_o, ld ? ref_load(fun, addr, data) : val);
      chk({tag, "_stall"},   w_stall_o, 0);
      chk({tag, "_err"},     w_load_err_o, 0);
   endtask

   initial begin
      rst_i = 1'b0;
      x_valid_i = 1'b0;
      x_rd_i = '0; x_rd_write_i = 1'b0; x_rd_value_i = '0; x_load_i = 1'b0;
      x_fun_i = '0; x_dm_addr_i = '0; dm_data_l_i = '0; dm_load_done_i = 1'b0;
      #12;
      chk("rst_stall", w_stall_o, 0);
      chk("rst_rd", w_rd_o, 0);
      chk("rst_value", w_rd_value_o, 0);
      chk("rst_store", w_rd_store_o, 0);
      chk("rst_byp_wr", w_bypass_rd_write_o, 0);
      chk("rst_byp_val", w_bypass_rd_value_o, 0);
      chk("rst_err", w_load_err_o, 0);
      @(negedge clk_i); rst_i = 1'b1;
      @(posedge clk_i); #1;

      run_instr("alu5", 5'd5, 1'b1, 32'h1234_5678, 1'b0, 3'd0, 2'd0, 32'h0, 0);
      idle(1'b0);
      run_instr("lb",  5'd3, 1'b1, 32'h0, 1'b1, 3'b000, 2'd2, 32'h80FF_7F00, 3);
      run_instr("lbu", 5'd4, 1'b1, 32'h0, 1'b1, 3'b100, 2'd2, 32'h80FF_7F00, 3);
      run_instr("lh",  5'd6, 1'b1, 32'h0, 1'b1, 3'b001, 2'd2, 32'h8001_ABCD, 1);
      run_instr("lhu", 5'd7, 1'b1, 32'h0, 1'b1, 3'b101, 2'd2, 32'h8001_ABCD, 0);
      run_instr("lw",  5'd8, 1'b1, 32'h0, 1'b1, 3'b010, 2'd3, 32'hCAFE_F00D, 2);
      run_instr("lodd", 5'd9, 1'b1, 32'h0, 1'b1, 3'b111, 2'd1, 32'h1357_9BDF, 1);
      idle(1'b0);
      run_instr("alu0", 5'd0, 1'b1, 32'hDEAD_BEEF, 1'b0, 3'd0, 2'd0, 32'h0, 0);
      idle(1'b0);
      run_instr("ld0", 5'd0, 1'b1, 32'h0, 1'b1, 3'b010, 2'd0, 32'h1111_2222, 2);
      idle(1'b0);
      run_instr("tmo", 5'd10, 1'b1, 32'h0, 1'b1, 3'b010, 2'd0, 32'h0, 100);
      run_instr("after_tmo", 5'd11, 1'b1, 32'hA5A5_0001, 1'b0, 3'd0, 2'd0, 32'h0, 0);
      idle(1'b0);
      run_instr("done4", 5'd12, 1'b1, 32'h0, 1'b1, 3'b000, 2'd1, 32'h0000_8000, 4);
      run_instr("b2b", 5'd13, 1'b1, 32'h7777_0000, 1'b0, 3'd0, 2'd0, 32'h0, 0);
      idle(1'b1);
      idle(1'b1);

      // Reset while a load is pending; a late done must not produce a write.
      x_valid_i = 1'b1; x_rd_i = 5'd14; x_rd_write_i = 1'b1; x_load_i = 1'b1;
      x_fun_i = 3'b010; x_dm_addr_i = 2'd0; dm_load_done_i = 1'b0;
      @(posedge clk_i); #1;
      x_valid_i = 1'b0;
      chk("mid_stall1", w_stall_o, 1);
      @(posedge clk_i); #1;
      chk("mid_stall2", w_stall_o, 1);
      rst_i = 1'b0;
      #1;
      chk("mid_rst_stall", w_stall_o, 0);
      chk("mid_rst_store", w_rd_store_o, 0);
      chk("mid_rst_value", w_rd_value_o, 0);
      chk("mid_rst_err", w_load_err_o, 0);
      @(negedge clk_i); rst_i = 1'b1;
      dm_load_done_i = 1'b1; dm_data_l_i = 32'hFFFF_FFFF;
      @(posedge clk_i); #1;
      dm_load_done_i = 1'b0;
      chk_quiet("post_rst1");
      idle(1'b0);

      // Randomized traffic against the reference rules.
      for (int n = 0; n < 250; n++) begin
         logic ld;
         int   dly;
         ld  = 1'($urandom);
         dly = $urandom_range(0, 6);
         run_instr("rnd", 5'($urandom), 1'($urandom), $urandom, ld, 3'($urandom),
                   2'($urandom), $urandom, dly);
         if ($urandom_range(0, 3) == 0) idle(1'($urandom));
      end
      idle(1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
